fifo_wr_ctrl: RTL and testbench

Write-side pointer and flag controller for the dual-clock asynchronous FIFO; counterpart of the read-side controller. It lives entirely in the write clock domain. It owns the binary write address and the Gray-coded write pointer exported to the read domain. It synchronises the read domain's Gray pointer and produces the full, almost-full, fill-level and overflow indications.

---
 rtl/fifo_wr_ctrl_pkg.sv | 25 ++
 rtl/fifo_ptr_sync.sv | 33 +++
 rtl/fifo_wr_ctrl.sv | 84 ++++++++
 tb/tb_fifo_wr_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared async-FIFO helpers: pointer code conversion and
// default geometry, used by both the write and read controllers.
package fifo_wr_ctrl_pkg;

   localparam int FIFO_AW = 4;
   localparam int DEPTH   = 2 ** FIFO_AW;
   localparam int PTR_W   = FIFO_AW + 1;

   // Binary to reflected Gray; zero-extended inputs stay exact.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Reflected Gray to binary; zero upper bits do not disturb
   // the low-order result, so narrower pointers may be widened.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-bit flop chain carrying a Gray pointer across clock
// domains; only one bit changes per source cycle.
module fifo_ptr_sync
   import fifo_wr_ctrl_pkg::*;
#(
   parameter int W      = PTR_W,
   parameter int STAGES = 2
) (
   input  logic         I_CLK,
   input  logic         I_RST,
   input  logic [W-1:0] I_D,
   output logic [W-1:0] O_Q
);

   logic [W-1:0] q [STAGES];

   // Shift the foreign pointer through the synchroniser stages.
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         for (int i = 0; i < STAGES; i++) begin
            q[i] <= '0;
         end
      end else begin
         q[0] <= I_D;
         for (int i = 1; i < STAGES; i++) begin
            q[i] <= q[i-1];
         end
      end
   end

   assign O_Q = q[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer and flag controller of the async FIFO.
// Owns the write address/Gray pointer and full/level flags.
module fifo_wr_ctrl
   import fifo_wr_ctrl_pkg::*;
#(
   parameter int AW          = FIFO_AW,
   parameter int AF_LVL      = DEPTH - 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic          I_WR_CLK,
   input  logic          I_WR_RST,
   input  logic          I_WR_EN,
   input  logic          I_WR_OVF_CLR,
   input  logic [AW:0]   I_WR_RD_PTR,
   output logic          O_WR_MEM_EN,
   output logic [AW-1:0] O_WR_ADDR,
   output logic [AW:0]   O_WR_PTR,
   output logic          O_WR_FULL,
   output logic          O_WR_ALMOST_FULL,
   output logic [AW:0]   O_WR_LEVEL,
   output logic          O_WR_OVERFLOW
);

   localparam int PW = AW + 1;

   logic [PW-1:0] bin_q;
   logic [PW-1:0] bin_next;
   logic [PW-1:0] gray_next;
   logic [PW-1:0] rd_sync;
   logic [PW-1:0] rd_bin;
   logic [PW-1:0] full_cmp;
   logic [PW-1:0] level_next;
   logic          accept;
   logic          full_next;
   logic          af_next;
   logic          ovf_next;

   fifo_ptr_sync #(
      .W      (PW),
      .STAGES (SYNC_STAGES)
   ) u_rd_sync (
      .I_CLK (I_WR_CLK),
      .I_RST (I_WR_RST),
      .I_D   (I_WR_RD_PTR),
      .O_Q   (rd_sync)
   );

   // Next pointer, flag and level values for this write edge.
   always_comb begin
      accept     = I_WR_EN & ~O_WR_FULL & ~I_WR_RST;
      bin_next   = bin_q + PW'(accept);
      gray_next  = PW'(bin2gray(32'(bin_next)));
      rd_bin     = PW'(gray2bin(32'(rd_sync)));
      full_cmp   = {~rd_sync[AW:AW-1], rd_sync[AW-2:0]};
      full_next  = (gray_next == full_cmp);
      level_next = bin_next - rd_bin;
      af_next    = (32'(level_next) >= AF_LVL);
      ovf_next   = (I_WR_EN & O_WR_FULL)
                 | (O_WR_OVERFLOW & ~I_WR_OVF_CLR);
   end

   // Register pointers and all status flags.
   always_ff @(posedge I_WR_CLK or posedge I_WR_RST) begin
      if (I_WR_RST) begin
         bin_q            <= '0;
         O_WR_PTR         <= '0;
         O_WR_FULL        <= 1'b0;
         O_WR_ALMOST_FULL <= 1'b0;
         O_WR_LEVEL       <= '0;
         O_WR_OVERFLOW    <= 1'b0;
      end else begin
         bin_q            <= bin_next;
         O_WR_PTR         <= gray_next;
         O_WR_FULL        <= full_next;
         O_WR_ALMOST_FULL <= af_next;
         O_WR_LEVEL       <= level_next;
         O_WR_OVERFLOW    <= ovf_next;
      end
   end

   assign O_WR_MEM_EN = accept;
   assign O_WR_ADDR   = bin_q[AW-1:0];

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed scenarios then random traffic,
// all checked against an occupancy-count reference model.
module tb_fifo_wr_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic       clr = 1'b0;
   logic [4:0] rd_ptr = '0;
   logic       mem_en;
   logic [3:0] addr;
   logic [4:0] ptr;
   logic       full;
   logic       af;
   logic [4:0] level;
   logic       ovf;

   int compared   = 0;
   int mismatched = 0;

   int m_wr;
   int m_rd;
   int m_lvl;
   bit m_full;
   bit m_af;
   bit m_ovf;
   int hist[$];

   fifo_wr_ctrl #(
      .AW          (4),
      .AF_LVL      (12),
      .SYNC_STAGES (2)
   ) dut (
      .I_WR_CLK         (clk),
      .I_WR_RST         (rst),
      .I_WR_EN          (en),
      .I_WR_OVF_CLR     (clr),
      .I_WR_RD_PTR      (rd_ptr),
      .O_WR_MEM_EN      (mem_en),
      .O_WR_ADDR        (addr),
      .O_WR_PTR         (ptr),
      .O_WR_FULL        (full),
      .O_WR_ALMOST_FULL (af),
      .O_WR_LEVEL       (level),
      .O_WR_OVERFLOW    (ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] gray5(input int x);
      int v;
      v = x % 32;
      return 5'(v ^ (v >> 1));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wr   = 0;
      m_rd   = 0;
      m_lvl  = 0;
      m_full = 0;
      m_af   = 0;
      m_ovf  = 0;
      hist   = {0, 0};
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_mem_en"}, 32'(mem_en), 0);
      chk({tag, "_addr"},   32'(addr),   0);
      chk({tag, "_ptr"},    32'(ptr),    0);
      chk({tag, "_full"},   32'(full),   0);
      chk({tag, "_af"},     32'(af),     0);
      chk({tag, "_level"},  32'(level),  0);
      chk({tag, "_ovf"},    32'(ovf),    0);
   endtask

   // One write-clock step starting and ending at a falling edge.
   task automatic cycle(input bit e, input bit c);
      bit acc;
      int used;
      en     = e;
      clr    = c;
      rd_ptr = gray5(m_rd);
      #1;
      acc = e && !m_full;
      chk("mem_en", 32'(mem_en), 32'(acc));
      chk("addr",   32'(addr),   32'(m_wr % 16));
      @(posedge clk);
      m_wr += int'(acc);
      hist.push_back(m_rd);
      used = hist[0];
      void'(hist.pop_front());
      m_lvl  = m_wr - used;
      m_ovf  = (e && m_full) || (m_ovf && !c);
      m_full = (m_lvl == 16);
      m_af   = (m_lvl >= 12);
      @(negedge clk);
      chk("ptr",   32'(ptr),   32'(gray5(m_wr)));
      chk("full",  32'(full),  32'(m_full));
      chk("af",    32'(af),    32'(m_af));
      chk("level", 32'(level), 32'(m_lvl));
      chk("ovf",   32'(ovf),   32'(m_ovf));
   endtask

   task automatic do_reset();
      en     = 1'b0;
      clr    = 1'b0;
      rd_ptr = '0;
      rst    = 1'b1;
      @(negedge clk);
      rst    = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [4:0] prev;
      model_reset();

      @(negedge clk);
      #1;
      chk_zero("por");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) cycle(1, 0);
      en = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk_zero("mid_rst");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b0;
      model_reset();

      for (int i = 0; i < 16; i++) begin
         cycle(1, 0);
         chk("af_rise",   32'(af),   32'(i >= 11));
         chk("full_edge", 32'(full), 32'(i == 15));
      end
      chk("fill_level", 32'(level), 16);
      chk("fill_ptr",   32'(ptr),   32'h18);

      cycle(1, 0);
      chk("ovf_set",  32'(ovf), 1);
      chk("ovf_ptr",  32'(ptr), 32'h18);
      cycle(0, 0);
      chk("ovf_hold", 32'(ovf), 1);
      cycle(1, 1);
      chk("ovf_setwin", 32'(ovf), 1);
      cycle(0, 1);
      chk("ovf_clr",  32'(ovf), 0);

      m_rd = 1;
      cycle(0, 0);
      chk("rel_lag1", 32'(full), 1);
      cycle(0, 0);
      chk("rel_lag2", 32'(full), 1);
      cycle(0, 0);
      chk("rel_full",  32'(full),  0);
      chk("rel_level", 32'(level), 15);
      #1;
      chk("rel_addr", 32'(addr), 0);
      cycle(1, 0);
      chk("refull", 32'(full), 1);

      do_reset();
      for (int i = 0; i < 40; i++) begin
         m_rd = (m_wr >= 4) ? m_wr - 4 : 0;
         prev = ptr;
         cycle(1, 0);
         chk("wrap_ham", 32'($countones(ptr ^ prev)), 1);
         chk("wrap_msb", 32'(ptr[4]), 32'(((i + 1) / 16) % 2));
         chk("wrap_nofull", 32'(full), 0);
         if (i >= 6) chk("wrap_lvl", 32'(level), 7);
      end

      do_reset();
      for (int i = 0; i < 5; i++) cycle(1, 0);
      for (int i = 0; i < 10; i++) begin
         cycle(0, 0);
         chk("idle_ptr",   32'(ptr),   32'h07);
         chk("idle_level", 32'(level), 5);
         chk("idle_full",  32'(full),  0);
      end

      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (m_rd < m_wr && $urandom_range(0, 2) == 0) m_rd++;
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
